multiplier_control_unit: RTL and testbench

Sequencing FSM for the 9-bit add/subtract computation path in the 8×8 signed add-shift multiplier. On a Run request it clears the A/X accumulator. It then issues N add-or-skip / shift step pairs, using subtract on the final step for the two's-complement sign correction, and holds the result until Run is released. It drives the computation module's Add/Sub/Clr_Ld controls and the shift-register shift/clear controls. It owns no datapath state.

---
 rtl/multiplier_pkg.sv | 17 +
 rtl/multiplier_control_unit.sv | 103 ++++++++++
 tb/tb_multiplier_control_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_pkg.sv
// Shared definitions for the 8x8 signed add-shift multiplier control path.
// The state enum is also used by the testbench to probe the controller state.
package multiplier_pkg;

  // Default number of multiplier bits (add/shift iterations per multiply).
  localparam int MULT_BITS = 8;

  // Controller states: clear, N add/shift step pairs, then hold the product.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/multiplier_control_unit.sv
// Sequencing FSM for the add/subtract computation path of the signed
// add-shift multiplier. It owns no datapath state: it only decides, cycle by
// cycle, whether the datapath clears, adds, subtracts or shifts.
module multiplier_control_unit
  import multiplier_pkg::*;
#(
  parameter int N = MULT_BITS
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_clearALoadB,
  input  logic i_m,
  output logic o_clrLd,
  output logic o_clearA,
  output logic o_add,
  output logic o_sub,
  output logic o_shift,
  output logic o_done
);

  // A 1-bit counter is kept even when N would need zero bits, so the
  // compare against the last step is always well formed.
  localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_nextState;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_nextStep;
  logic              w_lastStep;

  assign w_lastStep = (r_step == LAST_STEP);

  // State and step counter register; reset returns to IDLE with step 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_nextState;
      r_step  <= w_nextStep;
    end
  end

  // Next-state and output decode; Add/Sub/Clr_Ld depend on live inputs.
  always_comb begin
    w_nextState = r_state;
    w_nextStep  = r_step;
    o_clrLd     = 1'b0;
    o_clearA    = 1'b0;
    o_add       = 1'b0;
    o_sub       = 1'b0;
    o_shift     = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        // Run wins over an operator clear/load request in the same cycle.
        o_clrLd = i_clearALoadB & ~i_run;
        if (i_run) begin
          w_nextState = START;
        end
      end
      START: begin
        o_clearA    = 1'b1;
        w_nextStep  = '0;
        w_nextState = ADD;
      end
      ADD: begin
        // The final multiplier bit carries negative weight, hence subtract.
        if (i_m) begin
          if (w_lastStep) begin
            o_sub = 1'b1;
          end else begin
            o_add = 1'b1;
          end
        end
        w_nextState = SHIFT;
      end
      SHIFT: begin
        o_shift = 1'b1;
        if (w_lastStep) begin
          w_nextState = HOLD;
        end else begin
          w_nextStep  = r_step + STEP_W'(1);
          w_nextState = ADD;
        end
      end
      HOLD: begin
        // Holding Run keeps the product; only a release re-arms the unit.
        o_done = 1'b1;
        if (!i_run) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextStep  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_multiplier_control_unit.sv
// Self-checking bench for multiplier_control_unit. A cycle-offset model of a
// multiply (clear cycle, then N add/shift pairs, then hold) predicts every
// output each cycle; directed sequences plus random traffic drive the unit.
module tb_multiplier_control_unit;
  import multiplier_pkg::*;

  localparam int N = MULT_BITS;
  localparam int HOLD_PHASE = 2 * N + 2;

  logic i_clk;
  logic i_reset;
  logic i_run;
  logic i_clearALoadB;
  logic i_m;
  logic o_clrLd;
  logic o_clearA;
  logic o_add;
  logic o_sub;
  logic o_shift;
  logic o_done;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = idle, 1 = clear cycle, 2..2N+1 = step pairs, 2N+2 = hold.
  int   phase      = 0;
  logic modelValid = 1'b0;

  int   shiftCount = 0;
  int   addCount   = 0;
  int   subCount   = 0;
  int   clearCount = 0;
  int   doneCount  = 0;
  logic sampledDone = 1'b0;

  multiplier_control_unit #(.N(N)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_run        (i_run),
    .i_clearALoadB(i_clearALoadB),
    .i_m          (i_m),
    .o_clrLd      (o_clrLd),
    .o_clearA     (o_clearA),
    .o_add        (o_add),
    .o_sub        (o_sub),
    .o_shift      (o_shift),
    .o_done       (o_done)
  );

  // Free-running clock, period 10.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b phase=%0d t=%0t", tag, observed, expected, phase, $time);
    end
  endtask

  task automatic checkInt(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkState(input string tag, input ctrl_state_t observed, input ctrl_state_t expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%s expected=%s t=%0t", tag, observed.name(), expected.name(), $time);
    end
  endtask

  // Compare every output and the state against the phase model for this cycle.
  task automatic checkOutput();
    ctrl_state_t expState;
    logic        isStep;
    logic        isAddCycle;
    int          stepIdx;
    isStep     = (phase >= 2) && (phase <= 2 * N + 1);
    isAddCycle = isStep && ((phase % 2) == 0);
    stepIdx    = isStep ? (phase - 2) / 2 : 0;
    if (phase == 0)               expState = IDLE;
    else if (phase == 1)          expState = START;
    else if (phase == HOLD_PHASE) expState = HOLD;
    else if (isAddCycle)          expState = ADD;
    else                          expState = SHIFT;

    sampledDone = o_done;
    if (o_shift === 1'b1)  shiftCount++;
    if (o_add === 1'b1)    addCount++;
    if (o_sub === 1'b1)    subCount++;
    if (o_clearA === 1'b1) clearCount++;
    if (o_done === 1'b1)   doneCount++;

    if (modelValid) begin
      checkState("state", ctrl_state_t'(dut.r_state), expState);
      checkBit("clrLd", o_clrLd, (phase == 0) && i_clearALoadB && !i_run);
      checkBit("clearA", o_clearA, phase == 1);
      checkBit("add", o_add, isAddCycle && i_m && (stepIdx < N - 1));
      checkBit("sub", o_sub, isAddCycle && i_m && (stepIdx == N - 1));
      checkBit("shift", o_shift, isStep && !isAddCycle);
      checkBit("done", o_done, phase == HOLD_PHASE);
    end
  endtask

  // Drive one cycle: inputs after the edge, check at negedge, advance model.
  task automatic applyStimulus(input logic run, input logic m, input logic cl, input logic rst);
    i_run         = run;
    i_m           = m;
    i_clearALoadB = cl;
    i_reset       = rst;
    @(negedge i_clk);
    checkOutput();
    @(posedge i_clk);
    if (rst) begin
      phase      = 0;
      modelValid = 1'b1;
    end else if (phase == 0) begin
      if (run) phase = 1;
    end else if (phase < HOLD_PHASE) begin
      phase++;
    end else if (!run) begin
      phase = 0;
    end
    #1;
  endtask

  function automatic logic mFor(input logic [15:0] pattern);
    if (phase >= 2 && phase <= 2 * N + 1) return pattern[(phase - 2) / 2];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic clearCounts();
    shiftCount = 0;
    addCount   = 0;
    subCount   = 0;
    clearCount = 0;
    doneCount  = 0;
  endtask

  // One Run pulse from IDLE; checks latency to Done and pulse totals.
  task automatic runMultiply(input logic [15:0] pattern);
    int lat;
    int expAdds;
    expAdds = 0;
    for (int i = 0; i < N - 1; i++) expAdds += int'(pattern[i]);
    clearCounts();
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    lat = 0;
    do begin
      lat++;
      applyStimulus(1'b0, mFor(pattern), 1'($urandom_range(0, 1)), 1'b0);
    end while (!sampledDone && lat < 60);
    checkInt("doneLatency", lat, HOLD_PHASE);
    checkInt("shiftPulses", shiftCount, N);
    checkInt("addPulses", addCount, expAdds);
    checkInt("subPulses", subCount, int'(pattern[N-1]));
    checkInt("clearPulses", clearCount, 1);
  endtask

  initial begin
    int guard;
    i_run = 1'b1; i_m = 1'b0; i_clearALoadB = 1'b0; i_reset = 1'b1;
    #1;

    // Reset for two cycles with Run high, then IDLE with Run still high.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkState("resetState", ctrl_state_t'(dut.r_state), IDLE);
    clearCounts();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (phase != 0 && guard < 60) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    checkInt("allOnesShifts", shiftCount, N);
    checkInt("allOnesAdds", addCount, N - 1);
    checkInt("allOnesSubs", subCount, 1);

    // All-ones and 0x0A multipliers, plus a negative-weight pattern.
    runMultiply(16'h00FF);
    runMultiply(16'h000A);
    runMultiply(16'h0081);

    // Run held for 40 cycles gives exactly one multiply.
    clearCounts();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    checkInt("heldRunClears", clearCount, 1);
    checkInt("heldRunShifts", shiftCount, N);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Operator clear/load request in IDLE, against Run, and mid-sequence.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (phase != 0 && guard < 60) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      guard++;
    end

    // Reset during the SHIFT of step 3, then silence, then a fresh multiply.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (phase != 9 && guard < 60) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    checkInt("reachedStep3Shift", phase, 9);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    clearCounts();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkInt("postResetPulses", shiftCount + addCount + subCount, 0);
    runMultiply(16'($urandom_range(0, 255)));

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 79) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
